// File: rtl/prog_ram_pkg.sv
// Shared types and constants for the program RAM and its nibble loader.
package prog_ram_pkg;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_ASSEMBLE,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    localparam int NIBBLE_W = 4;

    function automatic int nibbles_per_word(input int data_w);
        return data_w / NIBBLE_W;
    endfunction

endpackage

// File: rtl/prog_ram_loader.sv
// Program loader: assembles nibbles MSN-first into words and
// writes them to consecutive addresses starting at 0.
module prog_ram_loader
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_mode,
    input  logic              ld_valid,
    input  logic [3:0]        ld_nibble,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int NIBBLES_PER_WORD = nibbles_per_word(DATA_W);
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES_PER_WORD - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LD_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            LD_IDLE: begin
                if (ld_mode) begin
                    state_d = LD_ASSEMBLE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            LD_ASSEMBLE: begin
                ld_ready = 1'b1;
                if (!ld_mode) begin
                    state_d = LD_IDLE;
                end else if (ld_valid) begin
                    word_d = (word_q << NIBBLE_W) | DATA_W'(ld_nibble);
                    if (cnt_q == LAST_NIB) begin
                        cnt_d   = '0;
                        state_d = LD_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LD_WRITE: begin
                if (!ld_mode) begin
                    state_d = LD_IDLE;
                end else begin
                    wr_en = 1'b1;
                    // The pointer parks on the last address instead of wrapping.
                    if (ptr_q == '1) begin
                        state_d = LD_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = LD_ASSEMBLE;
                    end
                end
            end
            LD_DONE: begin
                ld_done = 1'b1;
                if (!ld_mode) begin
                    state_d = LD_IDLE;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    assign busy    = (state_q != LD_IDLE);
    assign wr_addr = ptr_q;
    assign wr_data = word_q;

endmodule

// File: rtl/prog_ram.sv
// Single-port program RAM with a CPU port and a nibble-serial loader
// that owns the array whenever a load is in progress.
module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              we_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_oe,
    input  logic              ld_mode,
    input  logic              ld_valid,
    input  logic [3:0]        ld_nibble,
    output logic              ld_ready,
    output logic              ld_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              ld_wr_en;
    logic [ADDR_W-1:0] ld_wr_addr;
    logic [DATA_W-1:0] ld_wr_data;
    logic              cpu_en;
    logic              cpu_wr;
    logic              cpu_rd;

    prog_ram_loader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_loader (
        .clk      (clk),
        .rst      (rst),
        .ld_mode  (ld_mode),
        .ld_valid (ld_valid),
        .ld_nibble(ld_nibble),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .busy     (busy),
        .wr_en    (ld_wr_en),
        .wr_addr  (ld_wr_addr),
        .wr_data  (ld_wr_data)
    );

    // The CPU port is live only while the loader is idle.
    assign cpu_en = !cs_n && !busy;
    assign cpu_wr = cpu_en && !we_n;
    assign cpu_rd = cpu_en && we_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            dout_oe <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            dout_oe <= cpu_rd;
            if (cpu_rd) begin
                dout <= mem[addr];
            end
            if (cpu_wr) begin
                mem[addr] <= din;
            end else if (ld_wr_en) begin
                mem[ld_wr_addr] <= ld_wr_data;
            end
        end
    end

endmodule
